// File: rtl/hypercpu_membus.sv
// CPU-to-memory bus bridge with a one-entry fetch buffer and bus wait timeout.
// Fetches hitting the buffer complete without a bus cycle; stores write through to it.
module hypercpu_membus #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        mclk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_phase,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic        cpu_we,
    output logic [31:0] cpu_rdata,
    output logic        cpu_done,
    output logic        cpu_err,
    output logic        bus_valid,
    input  logic        bus_ready,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic        bus_we,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [15:0] TMO = 16'(TIMEOUT_CYCLES);

    state_t      state, state_nxt;
    logic [15:0] wait_cnt, wait_cnt_nxt;
    logic        cap_phase, cap_phase_nxt;
    logic        fb_valid, fb_valid_nxt;
    logic [31:0] fb_addr, fb_addr_nxt;
    logic [31:0] fb_data, fb_data_nxt;

    logic [31:0] cpu_rdata_nxt;
    logic        cpu_done_nxt, cpu_err_nxt;
    logic        bus_valid_nxt, bus_we_nxt;
    logic [31:0] bus_addr_nxt, bus_wdata_nxt;

    logic        fb_hit;

    // Only fetches may hit; loads and stores always go to the bus.
    assign fb_hit = !cpu_phase && fb_valid && (cpu_addr == fb_addr);

    always_comb begin
        state_nxt     = state;
        wait_cnt_nxt  = wait_cnt;
        cap_phase_nxt = cap_phase;
        fb_valid_nxt  = fb_valid;
        fb_addr_nxt   = fb_addr;
        fb_data_nxt   = fb_data;
        cpu_rdata_nxt = cpu_rdata;
        cpu_done_nxt  = 1'b0;
        cpu_err_nxt   = 1'b0;
        bus_valid_nxt = bus_valid;
        bus_we_nxt    = bus_we;
        bus_addr_nxt  = bus_addr;
        bus_wdata_nxt = bus_wdata;

        case (state)
            IDLE: begin
                if (cpu_req) begin
                    cap_phase_nxt = cpu_phase;
                    if (fb_hit) begin
                        state_nxt     = DONE;
                        cpu_done_nxt  = 1'b1;
                        cpu_rdata_nxt = fb_data;
                    end else begin
                        state_nxt     = BUS;
                        wait_cnt_nxt  = '0;
                        bus_valid_nxt = 1'b1;
                        bus_addr_nxt  = cpu_addr;
                        bus_wdata_nxt = cpu_wdata;
                        bus_we_nxt    = cpu_we & cpu_phase;
                    end
                end
            end

            BUS: begin
                // Ready wins over timeout when both land in the same cycle.
                if (bus_ready) begin
                    state_nxt     = DONE;
                    bus_valid_nxt = 1'b0;
                    bus_we_nxt    = 1'b0;
                    cpu_done_nxt  = 1'b1;
                    if (!bus_we) cpu_rdata_nxt = bus_rdata;
                    if (!cap_phase) begin
                        fb_valid_nxt = 1'b1;
                        fb_addr_nxt  = bus_addr;
                        fb_data_nxt  = bus_rdata;
                    end else if (bus_we && fb_valid && (bus_addr == fb_addr)) begin
                        fb_data_nxt = bus_wdata;
                    end
                end else if (wait_cnt >= TMO) begin
                    state_nxt     = DONE;
                    bus_valid_nxt = 1'b0;
                    bus_we_nxt    = 1'b0;
                    cpu_done_nxt  = 1'b1;
                    cpu_err_nxt   = 1'b1;
                    cpu_rdata_nxt = 32'hFFFF_FFFF;
                end else begin
                    wait_cnt_nxt = wait_cnt + 16'd1;
                end
            end

            DONE: state_nxt = IDLE;

            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge mclk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            cap_phase <= 1'b0;
            fb_valid  <= 1'b0;
            fb_addr   <= '0;
            fb_data   <= '0;
            cpu_rdata <= '0;
            cpu_done  <= 1'b0;
            cpu_err   <= 1'b0;
            bus_valid <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
        end else begin
            state     <= state_nxt;
            wait_cnt  <= wait_cnt_nxt;
            cap_phase <= cap_phase_nxt;
            fb_valid  <= fb_valid_nxt;
            fb_addr   <= fb_addr_nxt;
            fb_data   <= fb_data_nxt;
            cpu_rdata <= cpu_rdata_nxt;
            cpu_done  <= cpu_done_nxt;
            cpu_err   <= cpu_err_nxt;
            bus_valid <= bus_valid_nxt;
            bus_we    <= bus_we_nxt;
            bus_addr  <= bus_addr_nxt;
            bus_wdata <= bus_wdata_nxt;
        end
    end

endmodule
